// File: rtl/da_bitslice_feeder_pkg.sv
// Shared distributed-arithmetic constants and FSM encoding for the bit-slice
// feeder and the downstream DA accumulator.
package da_bitslice_feeder_pkg;

    localparam int NTAPS          = 64;
    localparam int NGROUPS        = 8;
    localparam int SAMPLE_W       = 8;
    localparam int TAPS_PER_GROUP = NTAPS / NGROUPS;
    localparam int BIT_W          = $clog2(SAMPLE_W);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLICE     = 2'd1,
        WAIT_DONE = 2'd2
    } da_state_e;

    typedef logic [NGROUPS-1:0][TAPS_PER_GROUP-1:0] da_addr_t;

    // The MSB slice carries the negative two's-complement weight.
    function automatic logic is_sign_bit(input logic [BIT_W-1:0] b);
        return (b == BIT_W'(SAMPLE_W - 1));
    endfunction

endpackage

// File: rtl/da_bitslice_feeder_slice_mux.sv
// Combinational bit-slice selector: gathers bit b of every tap into the
// eight DA ROM addresses, tap 8k+j landing on bit j of address k.
module da_slice_mux
    import da_bitslice_feeder_pkg::*;
(
    input  logic [SAMPLE_W-1:0] taps_i [NTAPS],
    input  logic [BIT_W-1:0]    bit_sel_i,
    output da_addr_t            addr_o
);

    // Transpose one bit plane of the delay line into per-group addresses.
    always_comb begin
        addr_o = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            for (int j = 0; j < TAPS_PER_GROUP; j++) begin
                addr_o[k][j] = taps_i[k*TAPS_PER_GROUP + j][bit_sel_i];
            end
        end
    end

endmodule

// File: rtl/da_bitslice_feeder.sv
// Bit-serial DA feeder: holds a 64-tap delay line and, per accepted sample,
// emits eight LSB-first bit slices as ROM addresses, then waits for da_done.
module da_bitslice_feeder
    import da_bitslice_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] x_in,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic                flush,
    output logic [7:0]          A7,
    output logic [7:0]          A6,
    output logic [7:0]          A5,
    output logic [7:0]          A4,
    output logic [7:0]          A3,
    output logic [7:0]          A2,
    output logic [7:0]          A1,
    output logic [7:0]          A0,
    output logic                start,
    output logic                slice_valid,
    output logic                sign_slice,
    input  logic                da_done,
    output logic                busy
);

    da_state_e           state_q, state_d;
    logic [BIT_W-1:0]    b_q, b_d;
    logic [SAMPLE_W-1:0] tap_q [NTAPS];
    logic [SAMPLE_W-1:0] tap_d [NTAPS];
    da_addr_t            addr_q, addr_d, mux_addr_s;
    logic                start_q, start_d;
    logic                slice_valid_q, slice_valid_d;
    logic                sign_q, sign_d;
    logic                slicing_s;

    assign x_ready = (state_q == IDLE) && !flush;
    assign busy    = (state_q != IDLE);

    // Outputs are computed from next-state values so the b = 0 slice is
    // visible in the first cycle after the accepting edge.
    da_slice_mux u_slice_mux (
        .taps_i    (tap_d),
        .bit_sel_i (b_d),
        .addr_o    (mux_addr_s)
    );

    // Next-state: FSM, bit counter and delay line.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        for (int i = 0; i < NTAPS; i++) begin
            tap_d[i] = tap_q[i];
        end
        case (state_q)
            IDLE: begin
                if (flush) begin
                    for (int i = 0; i < NTAPS; i++) begin
                        tap_d[i] = '0;
                    end
                end else if (x_valid) begin
                    tap_d[0] = x_in;
                    for (int i = 1; i < NTAPS; i++) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    state_d = SLICE;
                    b_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SLICE: begin
                if (is_sign_bit(b_q)) begin
                    state_d = WAIT_DONE;
                    b_d     = '0;
                end else begin
                    b_d = b_q + 3'd1;
                end
            end
            WAIT_DONE: begin
                if (da_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
                b_d     = '0;
            end
        endcase
    end

    // Slice output next values; everything is zero outside SLICE.
    always_comb begin
        slicing_s     = (state_d == SLICE);
        slice_valid_d = slicing_s;
        start_d       = slicing_s && (b_d == 3'd0);
        sign_d        = slicing_s && is_sign_bit(b_d);
        if (slicing_s) begin
            addr_d = mux_addr_s;
        end else begin
            addr_d = '0;
        end
    end

    // State, delay line and registered slice outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            b_q           <= '0;
            addr_q        <= '0;
            start_q       <= 1'b0;
            slice_valid_q <= 1'b0;
            sign_q        <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            b_q           <= b_d;
            addr_q        <= addr_d;
            start_q       <= start_d;
            slice_valid_q <= slice_valid_d;
            sign_q        <= sign_d;
            for (int i = 0; i < NTAPS; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    assign A0          = addr_q[0];
    assign A1          = addr_q[1];
    assign A2          = addr_q[2];
    assign A3          = addr_q[3];
    assign A4          = addr_q[4];
    assign A5          = addr_q[5];
    assign A6          = addr_q[6];
    assign A7          = addr_q[7];
    assign start       = start_q;
    assign slice_valid = slice_valid_q;
    assign sign_slice  = sign_q;

endmodule
